// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, saturating-count debouncer, press/release strobes.
// Optional long-press strobe built only when LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter bit          BTN_ACTIVE_LOW = 1'b0,
  parameter int unsigned HOLD_WIDTH     = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up,
  output logic pb_long
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (CNT_WIDTH < 1 || HOLD_WIDTH < 1) begin : g_bad_params
    $error("button_debounce: CNT_WIDTH and HOLD_WIDTH must be at least 1");
  end

  logic                 sync0;
  logic                 sync1;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt_c;
  logic                 idle_c;
  logic                 flip_c;

  // Only sync0 samples the asynchronous pin; both flops hold "pressed = 1".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= button ^ BTN_ACTIVE_LOW;
      sync1 <= sync0;
    end
  end

  always_comb begin
    idle_c    = (sync1 == pb_state);
    flip_c    = !idle_c && (cnt == CNT_MAX);
    cnt_nxt_c = idle_c ? '0 : cnt + CNT_WIDTH'(1);
  end

  // Debounced level and strobes change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pb_state <= 1'b0;
      pb_down  <= 1'b0;
      pb_up    <= 1'b0;
    end else begin
      cnt      <= cnt_nxt_c;
      pb_state <= pb_state ^ flip_c;
      pb_down  <= flip_c & ~pb_state;
      pb_up    <= flip_c & pb_state;
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;

  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [HOLD_WIDTH-1:0] hold_nxt_c;
  logic                  long_hit_c;

  // Clear on the falling edge itself so a short press never reaches saturation.
  always_comb begin
    hold_nxt_c = hold_cnt;
    if (!pb_state || flip_c) begin
      hold_nxt_c = '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_nxt_c = hold_cnt + HOLD_WIDTH'(1);
    end
    long_hit_c = (hold_nxt_c == HOLD_MAX) && (hold_cnt != HOLD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      pb_long  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt_c;
      pb_long  <= long_hit_c;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_long <= 1'b0;
    end else begin
      pb_long <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (CNT_WIDTH=4, HOLD_WIDTH=6); second instance is active-low.
module tb_button_debounce;

`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic button_al = 1'b1;
  logic pb_state, pb_down, pb_up, pb_long;
  logic al_state, al_down, al_up, al_long;

  int n_cmp = 0;
  int n_err = 0;
  int n_down = 0, n_up = 0, n_long = 0, n_both = 0;
  int al_n_down = 0, al_n_up = 0, al_n_both = 0;

  button_debounce #(.CNT_WIDTH(4), .BTN_ACTIVE_LOW(1'b0), .HOLD_WIDTH(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up), .pb_long(pb_long)
  );

  button_debounce #(.CNT_WIDTH(4), .BTN_ACTIVE_LOW(1'b1), .HOLD_WIDTH(6)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .button(button_al),
    .pb_state(al_state), .pb_down(al_down), .pb_up(al_up), .pb_long(al_long)
  );

  always #5 clk = ~clk;

  // Strobe tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (pb_down) n_down <= n_down + 1;
    if (pb_up) n_up <= n_up + 1;
    if (pb_long) n_long <= n_long + 1;
    if (pb_down && pb_up) n_both <= n_both + 1;
    if (al_down) al_n_down <= al_n_down + 1;
    if (al_up) al_n_up <= al_n_up + 1;
    if (al_down && al_up) al_n_both <= al_n_both + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if ({pb_state, pb_down, pb_up, pb_long} !== 4'b0) begin n_err++; $display("FAIL reset_outs: got %b want 0000", {pb_state, pb_down, pb_up, pb_long}); end
    n_cmp++; if ({al_state, al_down, al_up, al_long} !== 4'b0) begin n_err++; $display("FAIL reset_outs_al: got %b want 0000", {al_state, al_down, al_up, al_long}); end
  endtask

  task automatic test_held_through_reset();
    int d0, u0;
    @(negedge clk) button = 1'b1;
    tick(3);
    n_cmp++; if (pb_state !== 1'b0) begin n_err++; $display("FAIL held_in_reset: pb_state=%b want 0", pb_state); end
    d0 = n_down; u0 = n_up;
    @(negedge clk) rst_n = 1'b1;
    tick(17);
    n_cmp++; if (pb_state !== 1'b0) begin n_err++; $display("FAIL held_early: pb_state=%b want 0 at edge 17", pb_state); end
    tick(1);
    n_cmp++; if ({pb_state, pb_down} !== 2'b11) begin n_err++; $display("FAIL held_rise: state,down=%b want 11 at edge 18", {pb_state, pb_down}); end
    tick(1);
    n_cmp++; if (n_down - d0 !== 1 || n_up !== u0) begin n_err++; $display("FAIL held_count: downs=%0d ups=%0d want 1 0", n_down - d0, n_up - u0); end
  endtask

  task automatic test_press_release();
    @(negedge clk) button = 1'b0;
    tick(25);
    n_cmp++; if (pb_state !== 1'b0) begin n_err++; $display("FAIL pr_setup: pb_state=%b want 0", pb_state); end
    @(negedge clk) button = 1'b1;
    tick(17);
    n_cmp++; if (pb_down !== 1'b0) begin n_err++; $display("FAIL pr_down_early: pb_down=%b want 0", pb_down); end
    tick(1);
    n_cmp++; if ({pb_state, pb_down, pb_up} !== 3'b110) begin n_err++; $display("FAIL pr_down: state,down,up=%b want 110", {pb_state, pb_down, pb_up}); end
    tick(1);
    n_cmp++; if (pb_down !== 1'b0) begin n_err++; $display("FAIL pr_down_width: pb_down=%b want 0", pb_down); end
    tick(11);
    @(negedge clk) button = 1'b0;
    tick(17);
    n_cmp++; if ({pb_state, pb_up} !== 2'b10) begin n_err++; $display("FAIL pr_up_early: state,up=%b want 10", {pb_state, pb_up}); end
    tick(1);
    n_cmp++; if ({pb_state, pb_down, pb_up} !== 3'b001) begin n_err++; $display("FAIL pr_up: state,down,up=%b want 001", {pb_state, pb_down, pb_up}); end
    tick(1);
    n_cmp++; if (pb_up !== 1'b0) begin n_err++; $display("FAIL pr_up_width: pb_up=%b want 0", pb_up); end
  endtask

  task automatic test_bounce();
    int d0, u0;
    d0 = n_down; u0 = n_up;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) button = (i % 2 == 0);
      tick(5);
    end
    n_cmp++; if (n_down !== d0 || n_up !== u0 || pb_state !== 1'b0) begin n_err++; $display("FAIL bounce_quiet: downs=%0d ups=%0d state=%b want 0 0 0", n_down - d0, n_up - u0, pb_state); end
    @(negedge clk) button = 1'b1;
    tick(17);
    n_cmp++; if (pb_state !== 1'b0) begin n_err++; $display("FAIL bounce_early: pb_state=%b want 0", pb_state); end
    tick(1);
    n_cmp++; if ({pb_state, pb_down} !== 2'b11) begin n_err++; $display("FAIL bounce_down: state,down=%b want 11", {pb_state, pb_down}); end
    tick(1);
    n_cmp++; if (n_down - d0 !== 1) begin n_err++; $display("FAIL bounce_count: downs=%0d want 1", n_down - d0); end
  endtask

  task automatic test_reset_mid_debounce();
    @(negedge clk) button = 1'b0;
    tick(20);
    n_cmp++; if (pb_state !== 1'b0) begin n_err++; $display("FAIL mid_setup: pb_state=%b want 0", pb_state); end
    @(negedge clk) button = 1'b1;
    tick(10);
    @(negedge clk) rst_n = 1'b0;
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(17);
    n_cmp++; if ({pb_state, pb_down} !== 2'b00) begin n_err++; $display("FAIL mid_early: state,down=%b want 00 at edge 17", {pb_state, pb_down}); end
    tick(1);
    n_cmp++; if ({pb_state, pb_down} !== 2'b11) begin n_err++; $display("FAIL mid_down: state,down=%b want 11 at edge 18", {pb_state, pb_down}); end
    // Assert reset between edges while pb_state and pb_down are high.
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({pb_state, pb_down, pb_up} !== 3'b000) begin n_err++; $display("FAIL async_reset: state,down,up=%b want 000", {pb_state, pb_down, pb_up}); end
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(18);
    n_cmp++; if ({pb_state, pb_down} !== 2'b11) begin n_err++; $display("FAIL reassert_down: state,down=%b want 11", {pb_state, pb_down}); end
  endtask

  task automatic test_active_low();
    int d0, u0;
    d0 = al_n_down; u0 = al_n_up;
    @(negedge clk) button_al = 1'b0;
    tick(17);
    n_cmp++; if (al_state !== 1'b0) begin n_err++; $display("FAIL al_early: al_state=%b want 0", al_state); end
    tick(1);
    n_cmp++; if ({al_state, al_down} !== 2'b11) begin n_err++; $display("FAIL al_down: state,down=%b want 11", {al_state, al_down}); end
    tick(22);
    n_cmp++; if (al_state !== 1'b1 || al_n_down - d0 !== 1) begin n_err++; $display("FAIL al_hold: state=%b downs=%0d want 1 1", al_state, al_n_down - d0); end
    @(negedge clk) button_al = 1'b1;
    tick(18);
    n_cmp++; if ({al_state, al_up} !== 2'b01) begin n_err++; $display("FAIL al_up: state,up=%b want 01", {al_state, al_up}); end
    tick(1);
    n_cmp++; if (al_n_up - u0 !== 1 || al_up !== 1'b0) begin n_err++; $display("FAIL al_up_count: ups=%0d up=%b want 1 0", al_n_up - u0, al_up); end
  endtask

  task automatic test_back_to_back();
    int d0, u0;
    @(negedge clk) button = 1'b0;
    tick(20);
    d0 = n_down; u0 = n_up;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) button = 1'b1;
      tick(18);
      n_cmp++; if (pb_down !== 1'b1) begin n_err++; $display("FAIL b2b_down%0d: pb_down=%b want 1", k, pb_down); end
      @(negedge clk) button = 1'b0;
      tick(18);
      n_cmp++; if (pb_up !== 1'b1) begin n_err++; $display("FAIL b2b_up%0d: pb_up=%b want 1", k, pb_up); end
    end
    tick(2);
    n_cmp++; if (n_down - d0 !== 3 || n_up - u0 !== 3) begin n_err++; $display("FAIL b2b_count: downs=%0d ups=%0d want 3 3", n_down - d0, n_up - u0); end
    n_cmp++; if (n_both !== 0 || al_n_both !== 0) begin n_err++; $display("FAIL strobe_overlap: cycles=%0d/%0d want 0/0", n_both, al_n_both); end
  endtask

  task automatic test_long_press();
    int l0;
    l0 = n_long;
    @(negedge clk) button = 1'b1;
    tick(18);
    n_cmp++; if (pb_state !== 1'b1) begin n_err++; $display("FAIL long_rise: pb_state=%b want 1", pb_state); end
    tick(62);
    n_cmp++; if (pb_long !== 1'b0) begin n_err++; $display("FAIL long_early: pb_long=%b want 0", pb_long); end
    tick(1);
    n_cmp++; if (pb_long !== LONG_EN) begin n_err++; $display("FAIL long_pulse: pb_long=%b want %b", pb_long, LONG_EN); end
    tick(1);
    n_cmp++; if (pb_long !== 1'b0) begin n_err++; $display("FAIL long_width: pb_long=%b want 0", pb_long); end
    tick(18);
    @(negedge clk) button = 1'b0;
    tick(20);
    n_cmp++; if (n_long - l0 !== int'(LONG_EN)) begin n_err++; $display("FAIL long_count: pulses=%0d want %0d", n_long - l0, int'(LONG_EN)); end
    @(negedge clk) button = 1'b1;
    tick(40);
    @(negedge clk) button = 1'b0;
    tick(25);
    n_cmp++; if (n_long - l0 !== int'(LONG_EN) || pb_state !== 1'b0) begin n_err++; $display("FAIL short_hold: pulses=%0d state=%b want %0d 0", n_long - l0, pb_state, int'(LONG_EN)); end
    n_cmp++; if (al_long !== 1'b0) begin n_err++; $display("FAIL al_long: al_long=%b want 0", al_long); end
  endtask

  initial begin
    test_reset();
    test_held_through_reset();
    test_press_release();
    test_bounce();
    test_reset_mid_debounce();
    test_active_low();
    test_back_to_back();
    test_long_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
